// File: rtl/prim_util_pkg_u.sv
// Elaboration-time helpers for sizing counters and dividers.
package prim_util_pkg_u;

    // Bits needed to hold 0..value-1; never less than one.
    function automatic int vbits(int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int ceil_div(int num, int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/uart_pkg_u.sv
// Frame-format types shared by the UART receive and transmit paths.
package uart_pkg_u;

    localparam int UartDataW = 8;

    typedef enum logic [2:0] {
        RxIdle    = 3'd0,
        RxStart   = 3'd1,
        RxData    = 3'd2,
        RxParity  = 3'd3,
        RxStop    = 3'd4,
        RxBrkWait = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic frame_err;
        logic parity_err;
    } uart_rx_status_t;

endpackage

// File: rtl/uart_baud_tick_u.sv
// Free-running oversample tick divider; tick fires on the wrap cycle.
module uart_baud_tick_u
    import prim_util_pkg_u::*;
#(
    parameter int TickDiv = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int TickW = vbits(TickDiv);
    localparam logic [TickW-1:0] TickMax = TickW'(TickDiv - 1);

    logic [TickW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == TickMax);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == TickMax) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TickW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core_u.sv
// UART receiver: oversampled start/data/parity/stop deserialiser with break
// detection, feeding a 1-entry valid/ready output buffer.
module uart_rx_core_u
    import uart_pkg_u::*;
#(
    parameter int ClkFreq    = 50_000_000,
    parameter int BaudRate   = 115200,
    parameter int Oversample = 16,
    parameter int SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_enable_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 rx_i,
    output logic [UartDataW-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overflow_o,
    output logic                 break_o,
    output logic                 rx_busy_o
);

    localparam int TickDiv = prim_util_pkg_u::ceil_div(ClkFreq, BaudRate * Oversample);
    localparam int OvsW    = prim_util_pkg_u::vbits(Oversample);
    localparam logic [OvsW-1:0] OvsMid  = OvsW'(Oversample / 2 - 1);
    localparam logic [OvsW-1:0] OvsLast = OvsW'(Oversample - 1);

    rx_state_e            state_q, state_d;
    logic                 tick;
    logic [SyncStages-1:0] sync_q;
    logic                 rx_sync;
    logic [2:0]           hist_q;
    logic                 maj;
    logic [OvsW-1:0]      ovs_q;
    logic [2:0]           bit_q;
    logic [UartDataW-1:0] shift_q;
    logic                 par_bit_q, par_en_q, par_odd_q, stop_q;
    logic                 commit_q, break_q;
    logic                 stop_sample, brk_hit, break_clr;
    logic [UartDataW-1:0] data_q;
    uart_rx_status_t      status_q;
    logic                 valid_q, overflow_q;

    uart_baud_tick_u #(.TickDiv(TickDiv)) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (rx_enable_i),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], rx_i};
            if (tick) begin
                hist_q <= {hist_q[1:0], rx_sync};
            end
        end
    end

    assign rx_sync = sync_q[SyncStages-1];
    assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RxIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!rx_enable_i) begin
            state_d = RxIdle;
        end else if (tick) begin
            case (state_q)
                RxIdle:    if (!rx_sync) state_d = RxStart;
                RxStart:   if (ovs_q == OvsMid) state_d = maj ? RxIdle : RxData;
                RxData:    if (ovs_q == OvsLast && bit_q == 3'd7) state_d = par_en_q ? RxParity : RxStop;
                RxParity:  if (ovs_q == OvsLast) state_d = RxStop;
                RxStop:    if (ovs_q == OvsLast) state_d = brk_hit ? RxBrkWait : RxIdle;
                RxBrkWait: if (maj) state_d = RxIdle;
                default:   state_d = RxIdle;
            endcase
        end
    end

    always_comb begin
        rx_busy_o   = (state_q != RxIdle);
        stop_sample = tick && (state_q == RxStop) && (ovs_q == OvsLast);
        // At the stop sample, maj is the stop bit itself.
        brk_hit     = (shift_q == '0) && !maj && (!par_en_q || !par_bit_q);
        break_clr   = !rx_enable_i || (tick && (state_q == RxBrkWait) && maj);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovs_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop_q    <= 1'b0;
            commit_q  <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            commit_q <= stop_sample;
            if (stop_sample) stop_q <= maj;
            if (stop_sample && brk_hit) begin
                break_q <= 1'b1;
            end else if (break_clr) begin
                break_q <= 1'b0;
            end
            if (!rx_enable_i) begin
                ovs_q <= '0;
                bit_q <= '0;
            end else if (tick) begin
                case (state_q)
                    RxIdle: begin
                        ovs_q <= '0;
                        bit_q <= '0;
                        if (!rx_sync) begin
                            par_en_q  <= parity_en_i;
                            par_odd_q <= parity_odd_i;
                        end
                    end
                    RxStart: ovs_q <= (ovs_q == OvsMid) ? '0 : ovs_q + OvsW'(1);
                    RxData, RxParity, RxStop: begin
                        if (ovs_q == OvsLast) begin
                            ovs_q <= '0;
                            if (state_q == RxData) begin
                                shift_q <= {maj, shift_q[UartDataW-1:1]};
                                bit_q   <= bit_q + 3'd1;
                            end
                            if (state_q == RxParity) par_bit_q <= maj;
                        end else begin
                            ovs_q <= ovs_q + OvsW'(1);
                        end
                    end
                    default: ovs_q <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= '0;
            status_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (commit_q) begin
                if (!valid_q || rx_ready_i) begin
                    data_q              <= shift_q;
                    status_q.frame_err  <= !stop_q;
                    status_q.parity_err <= par_en_q && ((^shift_q ^ par_bit_q) != par_odd_q);
                    valid_q             <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (valid_q && rx_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign frame_err_o  = status_q.frame_err;
    assign parity_err_o = status_q.parity_err;
    assign overflow_o   = overflow_q;
    assign break_o      = break_q;

endmodule

// File: tb/tb_uart_rx_core_u.sv
// Directed bench for uart_rx_core_u at 16x oversampling with TickDiv = 2 (32 clocks per bit).
module tb_uart_rx_core_u;

    localparam int BitClks = 32;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_enable_i = 1'b1;
    logic       parity_en_i = 1'b0;
    logic       parity_odd_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_err_o, parity_err_o, overflow_o, break_o, rx_busy_o;

    int checks = 0;
    int errors = 0;

    int         cap_cnt = 0;
    int         ovf_cnt = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;

    uart_rx_core_u #(
        .ClkFreq    (3_686_400),
        .BaudRate   (115200),
        .Oversample (16),
        .SyncStages (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_enable_i  (rx_enable_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overflow_o   (overflow_o),
        .break_o      (break_o),
        .rx_busy_o    (rx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i) begin
            cap_cnt  = cap_cnt + 1;
            cap_data = rx_data_o;
            cap_fe   = frame_err_o;
            cap_pe   = parity_err_o;
        end
        if (overflow_o) ovf_cnt = ovf_cnt + 1;
    end

    task automatic clk1();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) clk1();
    endtask

    task automatic send_bit(input logic v);
        rx_i = v;
        repeat (BitClks) clk1();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(stop);
        rx_i = 1'b1;
    endtask

    task automatic check_rx(input string name, input int base, input logic [7:0] d, input logic fe, input logic pe);
        checks++;
        if (cap_cnt - base !== 1) begin
            errors++;
            $display("FAIL %s count: got %0d frames, expected 1", name, cap_cnt - base);
        end
        checks++;
        if (cap_data !== d) begin
            errors++;
            $display("FAIL %s data: got %h, expected %h", name, cap_data, d);
        end
        checks++;
        if (cap_fe !== fe) begin
            errors++;
            $display("FAIL %s frame_err: got %b, expected %b", name, cap_fe, fe);
        end
        checks++;
        if (cap_pe !== pe) begin
            errors++;
            $display("FAIL %s parity_err: got %b, expected %b", name, cap_pe, pe);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (4) clk1();
        checks++;
        if ({rx_valid_o, rx_data_o, frame_err_o, parity_err_o, overflow_o, break_o, rx_busy_o} !== 14'h0) begin
            errors++;
            $display("FAIL reset outputs: got v=%b d=%h fe=%b pe=%b ov=%b brk=%b busy=%b, expected all 0",
                     rx_valid_o, rx_data_o, frame_err_o, parity_err_o, overflow_o, break_o, rx_busy_o);
        end
        rst_i = 1'b0;
        idle(64);
    endtask

    task automatic test_8n1();
        int base = cap_cnt;
        parity_en_i = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(64);
        check_rx("8n1_a5", base, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL 8n1 valid_after: got %b, expected 0", rx_valid_o);
        end
    endtask

    task automatic test_parity();
        int base;
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        base = cap_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(64);
        check_rx("even_3c_p1", base, 8'h3C, 1'b0, 1'b1);
        base = cap_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(64);
        check_rx("even_3c_p0", base, 8'h3C, 1'b0, 1'b0);
        parity_odd_i = 1'b1;
        base = cap_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(64);
        check_rx("odd_3c_p1", base, 8'h3C, 1'b0, 1'b0);
        base = cap_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(64);
        check_rx("odd_07_p1", base, 8'h07, 1'b0, 1'b1);
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
    endtask

    task automatic test_glitch();
        int base = cap_cnt;
        rx_i = 1'b0;
        repeat (6) clk1();
        checks++;
        if (rx_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch busy_rise: got %b, expected 1", rx_busy_o);
        end
        repeat (2) clk1();
        idle(50);
        checks++;
        if (rx_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch busy_fall: got %b, expected 0", rx_busy_o);
        end
        idle(400);
        checks++;
        if (cap_cnt != base || rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch no_frame: got %0d frames valid=%b, expected 0 frames valid=0",
                     cap_cnt - base, rx_valid_o);
        end
    endtask

    task automatic test_frame_err();
        int base = cap_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        idle(40);
        check_rx("ferr_55", base, 8'h55, 1'b1, 1'b0);
        checks++;
        if (break_o !== 1'b0) begin
            errors++;
            $display("FAIL ferr break: got %b, expected 0", break_o);
        end
        // The low stop tail can look like a new start bit; disabling aborts it.
        rx_enable_i = 1'b0;
        repeat (2) clk1();
        rx_enable_i = 1'b1;
        idle(64);
        checks++;
        if (rx_busy_o !== 1'b0 || cap_cnt - base != 1) begin
            errors++;
            $display("FAIL ferr disable: got busy=%b frames=%0d, expected busy=0 frames=1",
                     rx_busy_o, cap_cnt - base);
        end
    endtask

    task automatic test_break();
        int base = cap_cnt;
        rx_i = 1'b0;
        repeat (20 * BitClks) clk1();
        check_rx("break", base, 8'h00, 1'b1, 1'b0);
        checks++;
        if (break_o !== 1'b1 || rx_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL break held: got brk=%b busy=%b, expected 1 1", break_o, rx_busy_o);
        end
        idle(20);
        checks++;
        if (break_o !== 1'b0 || rx_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL break release: got brk=%b busy=%b, expected 0 0", break_o, rx_busy_o);
        end
        idle(64);
    endtask

    task automatic test_back_to_back();
        int base = cap_cnt;
        int obase = ovf_cnt;
        rx_ready_i = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(40);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(64);
        checks++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
            errors++;
            $display("FAIL b2b held: got valid=%b data=%h, expected 1 11", rx_valid_o, rx_data_o);
        end
        checks++;
        if (ovf_cnt - obase != 1) begin
            errors++;
            $display("FAIL b2b overflow: got %0d pulses, expected 1", ovf_cnt - obase);
        end
        rx_ready_i = 1'b1;
        clk1();
        check_rx("b2b_xfer", base, 8'h11, 1'b0, 1'b0);
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b valid_drop: got %b, expected 0", rx_valid_o);
        end
        idle(64);
    endtask

    task automatic test_reset_mid();
        int base = cap_cnt;
        logic [7:0] d = 8'h00;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_i = 1'b0;
        repeat (BitClks / 2) clk1();
        checks++;
        if (rx_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid busy_before: got %b, expected 1", rx_busy_o);
        end
        rst_i = 1'b1;
        rx_i  = 1'b1;
        clk1();
        checks++;
        if ({rx_valid_o, rx_data_o, frame_err_o, parity_err_o, overflow_o, break_o, rx_busy_o} !== 14'h0) begin
            errors++;
            $display("FAIL rstmid outputs: got v=%b d=%h busy=%b ov=%b, expected all 0",
                     rx_valid_o, rx_data_o, rx_busy_o, overflow_o);
        end
        rst_i = 1'b0;
        idle(400);
        checks++;
        if (cap_cnt != base) begin
            errors++;
            $display("FAIL rstmid discard: got %0d frames, expected 0", cap_cnt - base);
        end
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        idle(64);
        check_rx("rstmid_7e", base, 8'h7E, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
